logic_result_buffer: RTL and testbench

LOGIC_RESULT_BUFFER -- requirements
Module: logic_result_buffer

---
 rtl/logic_result_buffer.sv | 172 +++++++++++++++++
 tb/tb_logic_result_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_result_buffer.sv
// Two-entry result FIFO between the logic unit and writeback, plus the committed flag register.
// Define LOGIC_RESULT_FORWARD_EN to add registered forwarding of the newest buffered writeback entry.
module logic_result_buffer #(
    parameter int N = 32
) (
    input  logic         iCLOCK,
    input  logic         inRESET,
    input  logic         iEVENT_FLUSH,
    input  logic         iPREV_VALID,
    output logic         oPREV_BUSY,
    input  logic [N-1:0] iPREV_DATA,
    input  logic [4:0]   iPREV_FLAGS,
    input  logic [4:0]   iPREV_DESTINATION_REGNUM,
    input  logic         iPREV_WRITEBACK,
    input  logic         iPREV_FLAGS_WRITEBACK,
    output logic         oNEXT_VALID,
    input  logic         iNEXT_BUSY,
    output logic [N-1:0] oNEXT_DATA,
    output logic [4:0]   oNEXT_FLAGS,
    output logic [4:0]   oNEXT_DESTINATION_REGNUM,
    output logic         oNEXT_WRITEBACK,
    output logic         oNEXT_FLAGS_WRITEBACK,
    output logic [4:0]   oFLAGS,
    output logic [1:0]   oCOUNT
`ifdef LOGIC_RESULT_FORWARD_EN
    ,
    output logic         oFWD_VALID,
    output logic [4:0]   oFWD_REGNUM,
    output logic [N-1:0] oFWD_DATA
`endif
);

    logic [N-1:0] r_data   [2];
    logic [4:0]   r_flags_e[2];
    logic [4:0]   r_regnum [2];
    logic         r_wb     [2];
    logic         r_fwb    [2];

    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic [4:0]   r_flags;

    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_count_nxt;
    logic         w_wptr_nxt;
    logic         w_rptr_nxt;

    // Busy depends only on the occupancy register and flush, never on iNEXT_BUSY.
    assign oPREV_BUSY = (r_count == 2'd2) || iEVENT_FLUSH;
    assign oNEXT_VALID = (r_count != 2'd0);
    assign w_push = iPREV_VALID && !oPREV_BUSY;
    assign w_pop  = oNEXT_VALID && !iNEXT_BUSY && !iEVENT_FLUSH;

    always_comb begin
        w_count_nxt = r_count;
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        if (iEVENT_FLUSH) begin
            w_count_nxt = 2'd0;
            w_wptr_nxt  = 1'b0;
            w_rptr_nxt  = 1'b0;
        end else begin
            w_wptr_nxt = r_wptr ^ w_push;
            w_rptr_nxt = r_rptr ^ w_pop;
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            r_flags <= 5'b00000;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            if (w_pop && r_fwb[r_rptr])
                r_flags <= r_flags_e[r_rptr];
        end
    end

    // Payload is left untouched on flush; only the pointers and count are cleared.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i]    <= '0;
                r_flags_e[i] <= 5'b00000;
                r_regnum[i]  <= 5'b00000;
                r_wb[i]      <= 1'b0;
                r_fwb[i]     <= 1'b0;
            end
        end else if (w_push) begin
            r_data[r_wptr]    <= iPREV_DATA;
            r_flags_e[r_wptr] <= iPREV_FLAGS;
            r_regnum[r_wptr]  <= iPREV_DESTINATION_REGNUM;
            r_wb[r_wptr]      <= iPREV_WRITEBACK;
            r_fwb[r_wptr]     <= iPREV_FLAGS_WRITEBACK;
        end
    end

    assign oNEXT_DATA               = r_data[r_rptr];
    assign oNEXT_FLAGS              = r_flags_e[r_rptr];
    assign oNEXT_DESTINATION_REGNUM = r_regnum[r_rptr];
    assign oNEXT_WRITEBACK          = r_wb[r_rptr];
    assign oNEXT_FLAGS_WRITEBACK    = r_fwb[r_rptr];
    assign oFLAGS                   = r_flags;
    assign oCOUNT                   = r_count;

`ifdef LOGIC_RESULT_FORWARD_EN
    logic         r_fwd_valid;
    logic [4:0]   r_fwd_regnum;
    logic [N-1:0] r_fwd_data;

    logic         w_new_idx;
    logic         w_old_idx;
    logic         w_new_wr;
    logic         w_old_wr;
    logic         w_new_wb;
    logic         w_old_wb;
    logic         w_fwd_valid_nxt;
    logic [4:0]   w_fwd_regnum_nxt;
    logic [N-1:0] w_fwd_data_nxt;

    // Forwarding is computed from the post-edge buffer contents so the outputs stay register-driven.
    assign w_new_idx = ~w_wptr_nxt;
    assign w_old_idx = w_wptr_nxt;
    assign w_new_wr  = w_push && (r_wptr == w_new_idx);
    assign w_old_wr  = w_push && (r_wptr == w_old_idx);
    assign w_new_wb  = w_new_wr ? iPREV_WRITEBACK : r_wb[w_new_idx];
    assign w_old_wb  = w_old_wr ? iPREV_WRITEBACK : r_wb[w_old_idx];

    always_comb begin
        w_fwd_valid_nxt  = 1'b0;
        w_fwd_regnum_nxt = 5'b00000;
        w_fwd_data_nxt   = '0;
        if ((w_count_nxt != 2'd0) && w_new_wb) begin
            w_fwd_valid_nxt  = 1'b1;
            w_fwd_regnum_nxt = w_new_wr ? iPREV_DESTINATION_REGNUM : r_regnum[w_new_idx];
            w_fwd_data_nxt   = w_new_wr ? iPREV_DATA : r_data[w_new_idx];
        end else if ((w_count_nxt == 2'd2) && w_old_wb) begin
            w_fwd_valid_nxt  = 1'b1;
            w_fwd_regnum_nxt = w_old_wr ? iPREV_DESTINATION_REGNUM : r_regnum[w_old_idx];
            w_fwd_data_nxt   = w_old_wr ? iPREV_DATA : r_data[w_old_idx];
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_fwd_valid  <= 1'b0;
            r_fwd_regnum <= 5'b00000;
            r_fwd_data   <= '0;
        end else begin
            r_fwd_valid  <= w_fwd_valid_nxt;
            r_fwd_regnum <= w_fwd_regnum_nxt;
            r_fwd_data   <= w_fwd_data_nxt;
        end
    end

    assign oFWD_VALID  = r_fwd_valid;
    assign oFWD_REGNUM = r_fwd_regnum;
    assign oFWD_DATA   = r_fwd_data;
`endif

endmodule

// File: tb/tb_logic_result_buffer.sv
// Bench for logic_result_buffer: directed vector table, random traffic against a queue model,
// and hand-written reset/forwarding sequences.
module tb_logic_result_buffer;

    localparam int N = 32;

    logic         iCLOCK = 1'b0;
    logic         inRESET = 1'b0;
    logic         iEVENT_FLUSH = 1'b0;
    logic         iPREV_VALID = 1'b0;
    logic         oPREV_BUSY;
    logic [N-1:0] iPREV_DATA = '0;
    logic [4:0]   iPREV_FLAGS = '0;
    logic [4:0]   iPREV_DESTINATION_REGNUM = '0;
    logic         iPREV_WRITEBACK = 1'b0;
    logic         iPREV_FLAGS_WRITEBACK = 1'b0;
    logic         oNEXT_VALID;
    logic         iNEXT_BUSY = 1'b0;
    logic [N-1:0] oNEXT_DATA;
    logic [4:0]   oNEXT_FLAGS;
    logic [4:0]   oNEXT_DESTINATION_REGNUM;
    logic         oNEXT_WRITEBACK;
    logic         oNEXT_FLAGS_WRITEBACK;
    logic [4:0]   oFLAGS;
    logic [1:0]   oCOUNT;
`ifdef LOGIC_RESULT_FORWARD_EN
    logic         oFWD_VALID;
    logic [4:0]   oFWD_REGNUM;
    logic [N-1:0] oFWD_DATA;
`endif

    logic_result_buffer #(.N(N)) dut (
        .iCLOCK(iCLOCK),
        .inRESET(inRESET),
        .iEVENT_FLUSH(iEVENT_FLUSH),
        .iPREV_VALID(iPREV_VALID),
        .oPREV_BUSY(oPREV_BUSY),
        .iPREV_DATA(iPREV_DATA),
        .iPREV_FLAGS(iPREV_FLAGS),
        .iPREV_DESTINATION_REGNUM(iPREV_DESTINATION_REGNUM),
        .iPREV_WRITEBACK(iPREV_WRITEBACK),
        .iPREV_FLAGS_WRITEBACK(iPREV_FLAGS_WRITEBACK),
        .oNEXT_VALID(oNEXT_VALID),
        .iNEXT_BUSY(iNEXT_BUSY),
        .oNEXT_DATA(oNEXT_DATA),
        .oNEXT_FLAGS(oNEXT_FLAGS),
        .oNEXT_DESTINATION_REGNUM(oNEXT_DESTINATION_REGNUM),
        .oNEXT_WRITEBACK(oNEXT_WRITEBACK),
        .oNEXT_FLAGS_WRITEBACK(oNEXT_FLAGS_WRITEBACK),
        .oFLAGS(oFLAGS),
        .oCOUNT(oCOUNT)
`ifdef LOGIC_RESULT_FORWARD_EN
        ,
        .oFWD_VALID(oFWD_VALID),
        .oFWD_REGNUM(oFWD_REGNUM),
        .oFWD_DATA(oFWD_DATA)
`endif
    );

    always #5 iCLOCK = ~iCLOCK;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  flags;
        logic        fwb;
        logic        nbusy;
        logic        flush;
        logic [1:0]  exp_count;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [4:0]  exp_flags;
        logic        exp_busy;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  flags;
        logic [4:0]  regnum;
        logic        wb;
        logic        fwb;
    } entry_t;

    entry_t     q[$];
    logic [4:0] m_flags;
    vec_t       tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic [4:0] f,
                                input logic fwb, input logic nb, input logic fl,
                                input logic [1:0] ec, input logic ev, input logic [31:0] ed,
                                input logic [4:0] ef, input logic eb);
        vec_t t;
        t.valid = v; t.data = d; t.flags = f; t.fwb = fwb; t.nbusy = nb; t.flush = fl;
        t.exp_count = ec; t.exp_valid = ev; t.exp_data = ed; t.exp_flags = ef; t.exp_busy = eb;
        return t;
    endfunction

    // Drives one cycle of inputs starting just after an edge; returns 1 time unit after the next edge.
    task automatic step(input logic v, input logic [31:0] d, input logic [4:0] f, input logic [4:0] rn,
                        input logic wb, input logic fwb, input logic nb, input logic fl);
        iPREV_VALID = v; iPREV_DATA = d; iPREV_FLAGS = f; iPREV_DESTINATION_REGNUM = rn;
        iPREV_WRITEBACK = wb; iPREV_FLAGS_WRITEBACK = fwb; iNEXT_BUSY = nb; iEVENT_FLUSH = fl;
        @(posedge iCLOCK);
        #1;
        iPREV_VALID = 1'b0;
        iEVENT_FLUSH = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        inRESET = 1'b0;
        #3;
        inRESET = 1'b1;
        q.delete();
        m_flags = 5'b00000;
        @(posedge iCLOCK);
        #1;
    endtask

    initial begin
        m_flags = 5'b00000;
        #2;
        chk("reset_count", 32'(oCOUNT), 32'd0);
        chk("reset_next_valid", 32'(oNEXT_VALID), 32'd0);
        chk("reset_prev_busy", 32'(oPREV_BUSY), 32'd0);
        chk("reset_flags", 32'(oFLAGS), 32'd0);
        chk("reset_next_data", oNEXT_DATA, 32'd0);
        #2;
        inRESET = 1'b1;
        @(posedge iCLOCK);
        #1;

        // v, data, flags, fwb, nbusy, flush | count, valid, data, flags, busy (after the edge)
        tbl[0]  = mk(1, 32'h0000_00FF, 5'b00001, 1, 0, 0, 2'd1, 1, 32'h0000_00FF, 5'b00000, 0);
        tbl[1]  = mk(0, 32'h0,         5'b00000, 0, 0, 0, 2'd0, 0, 32'h0,         5'b00001, 0);
        tbl[2]  = mk(1, 32'hA,         5'b11111, 0, 1, 0, 2'd1, 1, 32'hA,         5'b00001, 0);
        tbl[3]  = mk(1, 32'hB,         5'b11111, 0, 1, 0, 2'd2, 1, 32'hA,         5'b00001, 1);
        tbl[4]  = mk(1, 32'hC,         5'b11111, 0, 1, 0, 2'd2, 1, 32'hA,         5'b00001, 1);
        tbl[5]  = mk(0, 32'h0,         5'b00000, 0, 0, 0, 2'd1, 1, 32'hB,         5'b00001, 0);
        tbl[6]  = mk(0, 32'h0,         5'b00000, 0, 0, 0, 2'd0, 0, 32'h0,         5'b00001, 0);
        tbl[7]  = mk(1, 32'h3,         5'b00000, 0, 1, 0, 2'd1, 1, 32'h3,         5'b00001, 0);
        tbl[8]  = mk(1, 32'h5,         5'b00000, 0, 0, 0, 2'd1, 1, 32'h5,         5'b00001, 0);
        tbl[9]  = mk(0, 32'h0,         5'b00000, 0, 0, 0, 2'd0, 0, 32'h0,         5'b00001, 0);
        tbl[10] = mk(1, 32'h11,        5'b10000, 1, 1, 0, 2'd1, 1, 32'h11,        5'b00001, 0);
        tbl[11] = mk(1, 32'h22,        5'b01000, 1, 1, 0, 2'd2, 1, 32'h11,        5'b00001, 1);
        tbl[12] = mk(1, 32'h33,        5'b00100, 1, 0, 1, 2'd0, 0, 32'h0,         5'b00001, 0);
        tbl[13] = mk(0, 32'h0,         5'b00000, 0, 0, 0, 2'd0, 0, 32'h0,         5'b00001, 0);
        tbl[14] = mk(1, 32'h44,        5'b00010, 1, 1, 0, 2'd1, 1, 32'h44,        5'b00001, 0);
        tbl[15] = mk(0, 32'h0,         5'b00000, 0, 0, 0, 2'd0, 0, 32'h0,         5'b00010, 0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].valid, tbl[i].data, tbl[i].flags, 5'd1, 1'b1, tbl[i].fwb, tbl[i].nbusy, tbl[i].flush);
            #1;
            chk($sformatf("vec%0d_count", i), 32'(oCOUNT), 32'(tbl[i].exp_count));
            chk($sformatf("vec%0d_valid", i), 32'(oNEXT_VALID), 32'(tbl[i].exp_valid));
            chk($sformatf("vec%0d_flags", i), 32'(oFLAGS), 32'(tbl[i].exp_flags));
            chk($sformatf("vec%0d_busy", i), 32'(oPREV_BUSY), 32'(tbl[i].exp_busy));
            if (tbl[i].exp_valid)
                chk($sformatf("vec%0d_data", i), oNEXT_DATA, tbl[i].exp_data);
            @(posedge iCLOCK);
            #1;
        end

        // Random traffic against a queue model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            entry_t e;
            logic   m_push, m_pop, fl, v, nb;
            e.data   = $urandom;
            e.flags  = 5'($urandom);
            e.regnum = 5'($urandom);
            e.wb     = 1'($urandom);
            e.fwb    = 1'($urandom);
            v  = ($urandom_range(0, 99) < 60);
            nb = ($urandom_range(0, 99) < 35);
            fl = ($urandom_range(0, 99) < 5);
            iPREV_VALID = v; iPREV_DATA = e.data; iPREV_FLAGS = e.flags;
            iPREV_DESTINATION_REGNUM = e.regnum; iPREV_WRITEBACK = e.wb;
            iPREV_FLAGS_WRITEBACK = e.fwb; iNEXT_BUSY = nb; iEVENT_FLUSH = fl;
            #1;
            chk("rnd_count", 32'(oCOUNT), 32'(q.size()));
            chk("rnd_valid", 32'(oNEXT_VALID), 32'(q.size() != 0));
            chk("rnd_busy", 32'(oPREV_BUSY), 32'((q.size() == 2) || fl));
            chk("rnd_flags", 32'(oFLAGS), 32'(m_flags));
            if (q.size() != 0) begin
                chk("rnd_head_data", oNEXT_DATA, q[0].data);
                chk("rnd_head_fields",
                    {20'd0, oNEXT_FLAGS, oNEXT_DESTINATION_REGNUM, oNEXT_WRITEBACK, oNEXT_FLAGS_WRITEBACK},
                    {20'd0, q[0].flags, q[0].regnum, q[0].wb, q[0].fwb});
            end
`ifdef LOGIC_RESULT_FORWARD_EN
            begin
                logic        fv;
                logic [4:0]  fr;
                logic [31:0] fd;
                fv = 1'b0; fr = 5'd0; fd = 32'd0;
                for (int k = 0; k < q.size(); k++)
                    if (q[k].wb) begin fv = 1'b1; fr = q[k].regnum; fd = q[k].data; end
                chk("rnd_fwd_valid", 32'(oFWD_VALID), 32'(fv));
                if (fv) begin
                    chk("rnd_fwd_regnum", 32'(oFWD_REGNUM), 32'(fr));
                    chk("rnd_fwd_data", oFWD_DATA, fd);
                end
            end
`endif
            m_push = v && !((q.size() == 2) || fl);
            m_pop  = (q.size() != 0) && !nb;
            @(posedge iCLOCK);
            if (fl) begin
                q.delete();
            end else begin
                if (m_pop) begin
                    if (q[0].fwb) m_flags = q[0].flags;
                    void'(q.pop_front());
                end
                if (m_push) q.push_back(e);
            end
            #1;
        end
        iPREV_VALID = 1'b0;
        iEVENT_FLUSH = 1'b0;

        // Asynchronous reset while full, with non-zero committed flags
        do_reset();
        step(1, 32'h7, 5'b10101, 5'd2, 1, 1, 0, 0);
        step(0, 32'h0, 5'b00000, 5'd0, 0, 0, 0, 0);
        chk("pre_reset_flags", 32'(oFLAGS), 32'b10101);
        step(1, 32'h8, 5'b00000, 5'd2, 1, 0, 1, 0);
        step(1, 32'h9, 5'b00000, 5'd2, 1, 0, 1, 0);
        chk("pre_reset_count", 32'(oCOUNT), 32'd2);
        #2;
        inRESET = 1'b0;
        #1;
        chk("async_reset_count", 32'(oCOUNT), 32'd0);
        chk("async_reset_valid", 32'(oNEXT_VALID), 32'd0);
        chk("async_reset_busy", 32'(oPREV_BUSY), 32'd0);
        chk("async_reset_flags", 32'(oFLAGS), 32'd0);
        #1;
        inRESET = 1'b1;
        @(posedge iCLOCK);
        #1;
        step(1, 32'h1, 5'b00000, 5'd3, 1, 0, 1, 0);
        chk("post_reset_data", oNEXT_DATA, 32'h1);
        chk("post_reset_count", 32'(oCOUNT), 32'd1);

`ifdef LOGIC_RESULT_FORWARD_EN
        do_reset();
        step(1, 32'h10, 5'b00000, 5'd3, 1, 0, 1, 0);
        step(1, 32'h20, 5'b00000, 5'd4, 0, 0, 1, 0);
        chk("fwd_valid", 32'(oFWD_VALID), 32'd1);
        chk("fwd_regnum", 32'(oFWD_REGNUM), 32'd3);
        chk("fwd_data", oFWD_DATA, 32'h10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
